// File: rtl/vm_multi.sv
//------------------------------------------------------------------------------
// vm_multi : coin-operated vending controller with credit, vend and refund.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vm_multi #(
   parameter int CW         = 4,
   parameter int A_VAL      = 2,
   parameter int B_VAL      = 1,
   parameter int PRICE      = 3,
   parameter int MAX_CREDIT = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          coin_a,
   input  logic          coin_b,
   input  logic          buy,
   input  logic          cancel,
   output logic [CW-1:0] credit,
   output logic          vend,
   output logic [CW-1:0] change,
   output logic          chg_pulse,
   output logic          coin_rej,
   output logic          buy_nak,
   output logic          busy
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'b0001,
      S_ACCUM  = 4'b0010,
      S_VEND   = 4'b0100,
      S_REFUND = 4'b1000
   } state_t;

   localparam logic [CW:0]   c_a_wide = (CW+1)'(A_VAL);
   localparam logic [CW:0]   c_b_wide = (CW+1)'(B_VAL);
   localparam logic [CW:0]   c_max    = (CW+1)'(MAX_CREDIT);
   localparam logic [CW-1:0] c_a_val  = CW'(A_VAL);
   localparam logic [CW-1:0] c_b_val  = CW'(B_VAL);
   localparam logic [CW-1:0] c_price  = CW'(PRICE);
   localparam logic [CW-1:0] c_one    = CW'(1);

   state_t        state_q, state_d;
   logic [CW-1:0] credit_q, credit_d;
   logic [CW-1:0] change_q, change_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          vend_q, vend_d;
   logic          chg_pulse_q, chg_pulse_d;
   logic          coin_rej_q, coin_rej_d;
   logic          buy_nak_q, buy_nak_d;
   logic          busy_q, busy_d;

   logic          w_a_fits;
   logic          w_b_fits;
   logic          w_afford;
   logic          w_any_coin;

   // Fit test done one bit wider so a ceiling of 2^CW-1 can never wrap.
   assign w_a_fits   = ({1'b0, credit_q} + c_a_wide) <= c_max;
   assign w_b_fits   = ({1'b0, credit_q} + c_b_wide) <= c_max;
   assign w_afford   = credit_q >= c_price;
   assign w_any_coin = coin_a | coin_b;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         credit_q    <= '0;
         change_q    <= '0;
         cnt_q       <= '0;
         vend_q      <= 1'b0;
         chg_pulse_q <= 1'b0;
         coin_rej_q  <= 1'b0;
         buy_nak_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         credit_q    <= credit_d;
         change_q    <= change_d;
         cnt_q       <= cnt_d;
         vend_q      <= vend_d;
         chg_pulse_q <= chg_pulse_d;
         coin_rej_q  <= coin_rej_d;
         buy_nak_q   <= buy_nak_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      credit_d    = credit_q;
      change_d    = change_q;
      cnt_d       = cnt_q;
      vend_d      = 1'b0;
      chg_pulse_d = 1'b0;
      coin_rej_d  = 1'b0;
      buy_nak_d   = 1'b0;
      busy_d      = 1'b0;

      case (state_q)
         S_IDLE, S_ACCUM: begin
            if (cancel && (credit_q != '0)) begin
               state_d     = S_REFUND;
               change_d    = credit_q;
               cnt_d       = credit_q;
               credit_d    = '0;
               chg_pulse_d = 1'b1;
               busy_d      = 1'b1;
               coin_rej_d  = w_any_coin;
            end else if (buy && w_afford) begin
               state_d    = S_VEND;
               change_d   = credit_q - c_price;
               credit_d   = '0;
               vend_d     = 1'b1;
               busy_d     = 1'b1;
               coin_rej_d = w_any_coin;
            end else if (buy) begin
               // A refused buy still consumes the cycle; coins alongside it bounce.
               buy_nak_d  = 1'b1;
               coin_rej_d = w_any_coin;
            end else begin
               if (coin_a) begin
                  if (w_a_fits) begin
                     credit_d = credit_q + c_a_val;
                  end else begin
                     coin_rej_d = 1'b1;
                  end
               end
               if (coin_b) begin
                  if (coin_a || !w_b_fits) begin
                     coin_rej_d = 1'b1;
                  end else begin
                     credit_d = credit_q + c_b_val;
                  end
               end
               state_d = (credit_d != '0) ? S_ACCUM : S_IDLE;
            end
         end

         S_VEND: begin
            coin_rej_d = w_any_coin;
            if (change_q != '0) begin
               state_d     = S_REFUND;
               cnt_d       = change_q;
               chg_pulse_d = 1'b1;
               busy_d      = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_REFUND: begin
            // cnt_q counts the pulse shown this cycle, so 1 means the last one.
            coin_rej_d = w_any_coin;
            if (cnt_q <= c_one) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d       = cnt_q - c_one;
               chg_pulse_d = 1'b1;
               busy_d      = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign credit    = credit_q;
   assign change    = change_q;
   assign vend      = vend_q;
   assign chg_pulse = chg_pulse_q;
   assign coin_rej  = coin_rej_q;
   assign buy_nak   = buy_nak_q;
   assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_vm_multi.sv
//------------------------------------------------------------------------------
// tb_vm_multi : directed plus random stimulus against a behavioural model.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_vm_multi;

   localparam int CW         = 4;
   localparam int A_VAL      = 2;
   localparam int B_VAL      = 1;
   localparam int PRICE      = 3;
   localparam int MAX_CREDIT = 9;

   logic          clk;
   logic          rst;
   logic          coin_a, coin_b, buy, cancel;
   logic [CW-1:0] credit, change;
   logic          vend, chg_pulse, coin_rej, buy_nak, busy;

   int n_chk;
   int n_err;
   int pulses;
   int vend_seen;

   // Model: phase 0 = ready for coins, 1 = vending, 2 = paying change.
   int m_phase, m_credit, m_change, m_left;
   int m_vend, m_pulse, m_rej, m_nak;

   vm_multi #(
      .CW(CW), .A_VAL(A_VAL), .B_VAL(B_VAL), .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT)
   ) dut (
      .clk(clk), .rst(rst),
      .coin_a(coin_a), .coin_b(coin_b), .buy(buy), .cancel(cancel),
      .credit(credit), .vend(vend), .change(change), .chg_pulse(chg_pulse),
      .coin_rej(coin_rej), .buy_nak(buy_nak), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_credit = 0; m_change = 0; m_left = 0;
      m_vend = 0; m_pulse = 0; m_rej = 0; m_nak = 0;
   endtask

   task automatic model_edge(input bit ca, input bit cb, input bit b, input bit c);
      m_vend = 0; m_pulse = 0; m_rej = 0; m_nak = 0;
      if (m_phase == 1) begin
         m_rej = (ca || cb) ? 1 : 0;
         if (m_change > 0) begin
            m_phase = 2; m_left = m_change; m_pulse = 1;
         end else begin
            m_phase = 0;
         end
      end else if (m_phase == 2) begin
         m_rej  = (ca || cb) ? 1 : 0;
         m_left = m_left - 1;
         if (m_left == 0) m_phase = 0;
         else             m_pulse = 1;
      end else if (c && m_credit > 0) begin
         m_change = m_credit; m_credit = 0; m_phase = 2; m_left = m_change; m_pulse = 1;
         m_rej = (ca || cb) ? 1 : 0;
      end else if (b && m_credit >= PRICE) begin
         m_change = m_credit - PRICE; m_credit = 0; m_phase = 1; m_vend = 1;
         m_rej = (ca || cb) ? 1 : 0;
      end else if (b) begin
         m_nak = 1;
         m_rej = (ca || cb) ? 1 : 0;
      end else begin
         if (ca) begin
            if (m_credit + A_VAL <= MAX_CREDIT) m_credit += A_VAL;
            else                               m_rej = 1;
         end
         if (cb) begin
            if (ca || m_credit + B_VAL > MAX_CREDIT) m_rej = 1;
            else                                     m_credit += B_VAL;
         end
      end
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, ".credit"},    32'(credit),    32'(m_credit));
      chk({ctx, ".change"},    32'(change),    32'(m_change));
      chk({ctx, ".vend"},      32'(vend),      32'(m_vend));
      chk({ctx, ".chg_pulse"}, 32'(chg_pulse), 32'(m_pulse));
      chk({ctx, ".coin_rej"},  32'(coin_rej),  32'(m_rej));
      chk({ctx, ".buy_nak"},   32'(buy_nak),   32'(m_nak));
      chk({ctx, ".busy"},      32'(busy),      (m_phase != 0) ? 32'd1 : 32'd0);
   endtask

   task automatic step(input string ctx, input bit ca, input bit cb, input bit b, input bit c);
      coin_a = ca; coin_b = cb; buy = b; cancel = c;
      @(posedge clk);
      model_edge(ca, cb, b, c);
      #1;
      check_all(ctx);
      pulses    += int'(chg_pulse);
      vend_seen += int'(vend);
      @(negedge clk);
      coin_a = 1'b0; coin_b = 1'b0; buy = 1'b0; cancel = 1'b0;
   endtask

   initial begin
      int r;
      n_chk = 0; n_err = 0; pulses = 0; vend_seen = 0;
      rst = 1'b0; coin_a = 1'b0; coin_b = 1'b0; buy = 1'b0; cancel = 1'b0;
      model_reset();

      #3;
      check_all("reset");
      @(negedge clk);
      rst = 1'b1;

      // Two A coins then buy: change of 1 paid as one pulse.
      step("s1_a1", 1, 0, 0, 0);
      chk("s1_credit2", 32'(credit), 32'd2);
      step("s1_a2", 1, 0, 0, 0);
      chk("s1_credit4", 32'(credit), 32'd4);
      step("s1_buy", 0, 0, 1, 0);
      chk("s1_vend", 32'(vend), 32'd1);
      chk("s1_change", 32'(change), 32'd1);
      pulses = 0;
      step("s1_ref", 0, 0, 0, 0);
      step("s1_done", 0, 0, 0, 0);
      chk("s1_pulses", 32'(pulses), 32'd1);
      chk("s1_busy_low", 32'(busy), 32'd0);

      // Fill to the ceiling; one more B coin must bounce.
      for (int i = 0; i < 4; i++) step("s2_a", 1, 0, 0, 0);
      step("s2_b", 0, 1, 0, 0);
      chk("s2_credit9", 32'(credit), 32'd9);
      step("s2_b_over", 0, 1, 0, 0);
      chk("s2_rej", 32'(coin_rej), 32'd1);
      chk("s2_credit_hold", 32'(credit), 32'd9);

      // Buy at 9 gives change 6; reset after two pulses kills the rest.
      step("s5_buy", 0, 0, 1, 0);
      chk("s5_change6", 32'(change), 32'd6);
      pulses = 0;
      step("s5_p1", 0, 0, 0, 0);
      step("s5_p2", 0, 0, 0, 0);
      chk("s5_two_pulses", 32'(pulses), 32'd2);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all("s5_rst");
      chk("s5_rst_change", 32'(change), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) step("s5_after", 0, 0, 0, 0);
      chk("s5_no_pulses", 32'(pulses), 32'd0);

      // Cancel after two B coins: two pulses, no vend.
      pulses = 0; vend_seen = 0;
      step("s3_b1", 0, 1, 0, 0);
      step("s3_b2", 0, 1, 0, 0);
      step("s3_cancel", 0, 0, 0, 1);
      chk("s3_change2", 32'(change), 32'd2);
      for (int i = 0; i < 3; i++) step("s3_drain", 0, 0, 0, 0);
      chk("s3_pulses", 32'(pulses), 32'd2);
      chk("s3_no_vend", 32'(vend_seen), 32'd0);
      chk("s3_idle", 32'(busy), 32'd0);

      // Short credit buy is refused; simultaneous coins keep only A.
      step("s4_a", 1, 0, 0, 0);
      step("s4_buy", 0, 0, 1, 0);
      chk("s4_nak", 32'(buy_nak), 32'd1);
      chk("s4_credit2", 32'(credit), 32'd2);
      step("s4_ab", 1, 1, 0, 0);
      chk("s4_credit4", 32'(credit), 32'd4);
      chk("s4_rej", 32'(coin_rej), 32'd1);

      // Coin during refund bounces and credit stays empty.
      step("s6_cancel", 0, 0, 0, 1);
      step("s6_coin", 1, 0, 0, 0);
      chk("s6_rej", 32'(coin_rej), 32'd1);
      chk("s6_credit0", 32'(credit), 32'd0);
      for (int i = 0; i < 5; i++) step("s6_drain", 0, 0, 0, 0);

      // Random traffic; a buy or cancel is never mixed with coins.
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 99));
         if      (r < 30) step("rnd", 1, 0, 0, 0);
         else if (r < 55) step("rnd", 0, 1, 0, 0);
         else if (r < 62) step("rnd", 1, 1, 0, 0);
         else if (r < 75) step("rnd", 0, 0, 1, 0);
         else if (r < 82) step("rnd", 0, 0, 0, 1);
         else             step("rnd", 0, 0, 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/vm_multi.md
VM_MULTI -- requirements
Module: vm_multi

Interface
REQ-001 SHALL provide parameter CW, default 4, width of credit/change counters.
REQ-002 SHALL provide parameter A_VAL, default 2, credit units added by coin_a.
REQ-003 SHALL provide parameter B_VAL, default 1, credit units added by coin_b.
REQ-004 SHALL provide parameter PRICE, default 3, credit units consumed per vend.
REQ-005 SHALL provide parameter MAX_CREDIT, default 9, credit ceiling (legal: PRICE <= MAX_CREDIT <= 2^CW-1).
REQ-006 SHALL have port clk input 1, single clock, all state on rising edge.
REQ-007 SHALL have port rst input 1, reset, asynchronous, active-low.
REQ-008 SHALL have port coin_a input 1, one-cycle pulse, coin of value A_VAL inserted.
REQ-009 SHALL have port coin_b input 1, one-cycle pulse, coin of value B_VAL inserted.
REQ-010 SHALL have port buy input 1, purchase request.
REQ-011 SHALL have port cancel input 1, refund request.
REQ-012 SHALL have port credit output CW, current accumulated credit.
REQ-013 SHALL have port vend output 1, one-cycle product-release pulse.
REQ-014 SHALL have port change output CW, total change of the last transaction, held until next vend/refund.
REQ-015 SHALL have port chg_pulse output 1, one pulse per returned credit unit.
REQ-016 SHALL have port coin_rej output 1, one-cycle pulse, coin rejected.
REQ-017 SHALL have port buy_nak output 1, one-cycle pulse, buy refused for insufficient credit.
REQ-018 SHALL have port busy output 1, high in VEND and REFUND.

Function
REQ-019 SHALL implement states IDLE, ACCUM, VEND, REFUND, state register one-hot; all outputs registered.
REQ-020 IDLE/ACCUM: accepted coin SHALL add its value to credit at the next edge; IDLE->ACCUM when credit becomes nonzero.
REQ-021 A coin that would make credit exceed MAX_CREDIT SHALL be rejected: coin_rej=1 next cycle, credit unchanged.
REQ-022 coin_a and coin_b in the same cycle: coin_a SHALL be processed, coin_b rejected (coin_rej=1).
REQ-023 Priority in IDLE/ACCUM SHALL be cancel > buy > coin; any coin in the same cycle as an acted-on buy/cancel SHALL be rejected.
REQ-024 buy sampled at edge N with credit >= PRICE: at N+1 state=VEND, vend=1, change=credit-PRICE, credit=0, busy=1.
REQ-025 buy with credit < PRICE: buy_nak=1 at N+1, state and credit unchanged.
REQ-026 cancel with credit > 0: at N+1 state=REFUND, change=credit, credit=0, busy=1, no vend; cancel with credit 0 SHALL be ignored.
REQ-027 VEND SHALL last one cycle, then go to REFUND if change>0, else IDLE.
REQ-028 REFUND SHALL assert chg_pulse for exactly change consecutive cycles using an internal down-counter, then return to IDLE with busy=0 the following cycle.
REQ-029 In VEND/REFUND any coin SHALL be rejected (coin_rej=1); buy and cancel SHALL be ignored.
REQ-030 All arithmetic SHALL be CW bits unsigned; no wrap-around permitted by REQ-021.

Reset
REQ-031 While rst=0: state=IDLE, credit=0, change=0, vend=0, chg_pulse=0, coin_rej=0, buy_nak=0, busy=0, refund counter=0, asynchronously.
REQ-032 Reset mid-VEND/REFUND SHALL abort the transaction; remaining chg_pulse units are lost.
REQ-033 First edge after rst rises SHALL sample inputs normally.

Verification (defaults)
REQ-034 coin_a, coin_a, buy -> credit 2,4; then vend=1, change=1, credit=0; one chg_pulse; busy low after.
REQ-035 coin_a x4, coin_b (credit 9), coin_b -> coin_rej=1, credit stays 9.
REQ-036 coin_b, coin_b, cancel -> change=2, two chg_pulse cycles, vend never asserted, IDLE.
REQ-037 coin_a, buy -> buy_nak=1, credit stays 2; coin_a+coin_b same cycle -> credit 4, coin_rej=1.
REQ-038 credit 9, buy -> vend, change=6; drop rst after 2 chg_pulse -> all outputs 0, state IDLE, no further pulses.
REQ-039 coin_a during REFUND -> coin_rej=1, credit remains 0.
